// File: rtl/keypad_pkg.sv
// Shared sizes, state/frame-class enums and a key-index helper for the keypad scanner.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int ROW_W    = $clog2(NUM_ROWS);
  localparam int COL_W    = $clog2(NUM_COLS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} scan_state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_class_t;

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [KEY_W-1:0] lowest_key(input logic [NUM_KEYS-1:0] map);
    lowest_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (map[i]) lowest_key = KEY_W'(i);
    end
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every RATE clocks, on the last count.
// Tick is decoded combinationally from the count; no backpressure.
module scan_tick_gen #(
  parameter int RATE = 125000
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);
  localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATE - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);
endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad one column per SCAN_RATE clocks and debounces whole frames.
// Press reported up to (DEBOUNCE_SCANS+1) frames + 3 clocks after row settles; strobe output, no backpressure.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_RATE      = 125000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                multi_key
);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] r_row_m;
  logic [NUM_ROWS-1:0] r_row_s;
  logic [COL_W-1:0]    r_col_idx;
  logic [COL_W-1:0]    w_col_idx_nxt;
  logic [NUM_COLS-1:0] r_col;
  logic [NUM_KEYS-1:0] r_map;
  logic                r_frame_done;
  logic                r_multi;
  logic                w_tick;
  frame_class_t        w_cls;
  logic [KEY_W-1:0]    w_cand;
  logic                w_same;

  scan_state_t         r_state;
  scan_state_t         w_state_nxt;
  logic [KEY_W-1:0]    r_cand;
  logic [KEY_W-1:0]    w_cand_nxt;
  logic [KEY_W-1:0]    r_key_code;
  logic [KEY_W-1:0]    w_key_code_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                r_key_valid;
  logic                w_key_valid_nxt;
  logic                r_key_held;
  logic                w_key_held_nxt;

  scan_tick_gen #(.RATE(SCAN_RATE)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .tick (w_tick)
  );

  // row is asynchronous; idle level is all-ones (pulled up)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_row_m <= '1;
      r_row_s <= '1;
    end else begin
      r_row_m <= row;
      r_row_s <= r_row_m;
    end
  end

  assign w_col_idx_nxt = r_col_idx + 1'b1;

  // Sample at the end of each column period, then advance the column on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col_idx    <= '0;
      r_col        <= 4'b1110;
      r_map        <= '0;
      r_frame_done <= 1'b0;
      r_multi      <= 1'b0;
    end else begin
      r_frame_done <= w_tick && (r_col_idx == COL_LAST);
      if (w_tick) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
          r_map[{ROW_W'(r), r_col_idx}] <= ~r_row_s[r];
        end
        r_col_idx <= w_col_idx_nxt;
        r_col     <= ~(NUM_COLS'(1) << w_col_idx_nxt);
      end else if (r_frame_done) begin
        r_map   <= '0;
        r_multi <= (w_cls == MULTI);
      end
    end
  end

  always_comb begin
    w_cls = NONE;
    if (r_map != '0) begin
      w_cls = ((r_map & (r_map - 1'b1)) == '0) ? SINGLE : MULTI;
    end
  end

  assign w_cand    = lowest_key(r_map);
  assign w_same    = (w_cls == SINGLE) && (w_cand == r_cand);
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_held  <= w_key_held_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cand_nxt      = r_cand;
    w_cnt_nxt       = r_cnt;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    w_key_held_nxt  = r_key_held;
    if (r_frame_done) begin
      unique case (r_state)
        IDLE: begin
          if (w_cls == SINGLE) begin
            w_cand_nxt = w_cand;
            w_cnt_nxt  = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              w_state_nxt     = PRESSED;
              w_key_code_nxt  = w_cand;
              w_key_valid_nxt = 1'b1;
              w_key_held_nxt  = 1'b1;
            end else begin
              w_state_nxt = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (w_same) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DEB_LAST) begin
              w_state_nxt     = PRESSED;
              w_key_code_nxt  = w_cand;
              w_key_valid_nxt = 1'b1;
              w_key_held_nxt  = 1'b1;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
        PRESSED: begin
          // An empty frame already counts toward release; anything else restarts it.
          if (!w_same) begin
            if (w_cls == NONE) begin
              w_cnt_nxt = CNT_W'(1);
              if (DEBOUNCE_SCANS == 1) begin
                w_state_nxt    = IDLE;
                w_key_held_nxt = 1'b0;
              end else begin
                w_state_nxt = RELEASE;
              end
            end else begin
              w_cnt_nxt   = '0;
              w_state_nxt = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (w_cls == NONE) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DEB_LAST) begin
              w_state_nxt    = IDLE;
              w_key_held_nxt = 1'b0;
            end
          end else if (w_same) begin
            w_state_nxt = PRESSED;
          end else begin
            w_cnt_nxt = '0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign col       = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign multi_key = r_multi;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model, frame-level vector table, timed corner cases, random frames.
module tb_keypad_scanner;
  localparam int SR = 4;
  localparam int DB = 3;
  localparam int S_IDLE = 0, S_DEB = 1, S_PRS = 2, S_REL = 3;

  typedef struct {
    logic [15:0] mask;
    int          v;
    int          h;
    int          code;
    int          m;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;
  logic [15:0] pressed = 16'h0000;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int snap = 0;
  vec_t tbl[$];

  int          m_st;
  int          m_cnt;
  int          m_held;
  int          m_multi;
  logic [3:0]  m_cand;
  logic [3:0]  m_code;

  keypad_scanner #(.SCAN_RATE(SR), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; rows are pulled up otherwise.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && pressed[r*4+c]) row[r] = 1'b0;
  end

  always @(negedge clk) if (key_valid === 1'b1) valid_cnt++;

  function automatic logic [15:0] km(input int n);
    km = 16'h0001 << n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] mk, input int v, input int h, input int c, input int m);
    vec_t e;
    e.mask = mk; e.v = v; e.h = h; e.code = c; e.m = m;
    tbl.push_back(e);
  endtask

  // Wait for the start of a new scan frame (col returns to 1110), then apply a key mask for that frame.
  task automatic step(input logic [15:0] mask);
    logic [3:0] prev;
    logic       found;
    prev  = col;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (col == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = col;
    end
    check("frame_sync", int'(found), 1);
    pressed = mask;
    @(negedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int idx, input int ev, input int eh,
                             input int ec, input int em);
    int d;
    d = valid_cnt - snap;
    snap = valid_cnt;
    check($sformatf("%s[%0d].valid_pulses", tag, idx), d, ev);
    check($sformatf("%s[%0d].key_held", tag, idx), int'(key_held), eh);
    check($sformatf("%s[%0d].key_code", tag, idx), int'(key_code), ec);
    check($sformatf("%s[%0d].multi_key", tag, idx), int'(multi_key), em);
  endtask

  // Frame-level reference: classify the frame's key set and advance the debounce rules.
  task automatic model_frame(input logic [15:0] mask, output int v);
    int n;
    int k;
    int same;
    n = 0;
    k = 0;
    for (int i = 15; i >= 0; i--) if (mask[i]) begin n++; k = i; end
    v = 0;
    m_multi = (n > 1) ? 1 : 0;
    same = (n == 1 && k == int'(m_cand)) ? 1 : 0;
    case (m_st)
      S_IDLE: if (n == 1) begin
        m_cand = 4'(k);
        m_cnt  = 1;
        if (m_cnt >= DB) begin m_st = S_PRS; m_code = m_cand; m_held = 1; v = 1; end
        else m_st = S_DEB;
      end
      S_DEB: if (same == 1) begin
        m_cnt++;
        if (m_cnt >= DB) begin m_st = S_PRS; m_code = m_cand; m_held = 1; v = 1; end
      end else m_st = S_IDLE;
      S_PRS: if (same == 0) begin
        m_cnt = (n == 0) ? 1 : 0;
        m_st  = S_REL;
        if (m_cnt >= DB) begin m_st = S_IDLE; m_held = 0; end
      end
      default: begin
        if (n == 0) begin
          m_cnt++;
          if (m_cnt >= DB) begin m_st = S_IDLE; m_held = 0; end
        end else if (same == 1) m_st = S_PRS;
        else m_cnt = 0;
      end
    endcase
  endtask

  task automatic wait_valid(input int lim, output int cyc);
    cyc = -1;
    for (int i = 1; i <= lim && cyc < 0; i++) begin
      @(negedge clk);
      #1;
      if (key_valid) cyc = i;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int s0;
    int pv;
    int r;
    int fav;
    logic [15:0] mk;
    logic [3:0]  ecol;

    // Frame-level vectors: {mask, key_valid pulses, key_held, key_code, multi_key} after each frame.
    add(16'h0, 0,0,0,0);  add(km(6),0,0,0,0);   add(km(6),0,0,0,0);  add(km(6),1,1,6,0);
    add(km(6),0,1,6,0);   add(16'h0,0,1,6,0);   add(km(6),0,1,6,0);  add(16'h0,0,1,6,0);
    add(16'h0,0,1,6,0);   add(16'h0,0,0,6,0);   add(km(6),0,0,6,0);  add(16'h0,0,0,6,0);
    add(km(6),0,0,6,0);   add(km(6),0,0,6,0);   add(16'h0,0,0,6,0);  add(km(0)|km(5),0,0,6,1);
    add(km(0)|km(5),0,0,6,1); add(km(0),0,0,6,0); add(km(0),0,0,6,0); add(km(0),1,1,0,0);
    add(km(0),0,1,0,0);   add(km(5),0,1,0,0);   add(km(0),0,1,0,0);  add(km(0)|km(15),0,1,0,1);
    add(16'h0,0,1,0,0);   add(16'h0,0,1,0,0);   add(km(3),0,1,0,0);  add(16'h0,0,1,0,0);
    add(16'h0,0,1,0,0);   add(16'h0,0,0,0,0);   add(km(15),0,0,0,0); add(km(9),0,0,0,0);
    add(km(9),0,0,0,0);   add(km(9),0,0,0,0);   add(km(9),1,1,9,0);  add(16'h0,0,1,9,0);
    add(16'h0,0,1,9,0);   add(16'h0,0,0,9,0);   add(km(15),0,0,9,0); add(km(15),0,0,9,0);
    add(km(15),1,1,15,0); add(16'h0,0,1,15,0);  add(km(15),0,1,15,0); add(16'h0,0,1,15,0);
    add(16'h0,0,1,15,0);  add(16'h0,0,0,15,0);

    // Reset values, then the idle column sweep.
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst.col", int'(col), 4'b1110);
    check("rst.key_code", int'(key_code), 0);
    check("rst.key_valid", int'(key_valid), 0);
    check("rst.key_held", int'(key_held), 0);
    check("rst.multi_key", int'(multi_key), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    s0 = valid_cnt;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      ecol = ~(4'b0001 << ((i / 4) % 4));
      check($sformatf("sweep[%0d].col", i), int'(col), int'(ecol));
    end
    check("sweep.valid_pulses", valid_cnt - s0, 0);
    check("sweep.key_held", int'(key_held), 0);
    check("sweep.key_code", int'(key_code), 0);

    // Key 6 held for 200 cycles from an arbitrary phase: one press, then release.
    repeat ($urandom_range(0, 15)) @(negedge clk);
    pressed = km(6);
    s0 = valid_cnt;
    wait_valid(70, cyc);
    check("press6.found_within_70", (cyc > 0) ? 1 : 0, 1);
    repeat (200 - ((cyc > 0) ? cyc : 70)) @(negedge clk);
    #1;
    check("press6.valid_pulses", valid_cnt - s0, 1);
    check("press6.key_code", int'(key_code), 6);
    check("press6.key_held", int'(key_held), 1);
    pressed = 16'h0;
    cyc = -1;
    for (int i = 1; i <= 70 && cyc < 0; i++) begin
      @(negedge clk);
      #1;
      if (!key_held) cyc = i;
    end
    check("release6.held_low_within_70", (cyc > 0) ? 1 : 0, 1);

    // Frame table from a clean reset.
    pulse_reset();
    step(tbl[0].mask);
    snap = valid_cnt;
    for (int i = 1; i <= tbl.size(); i++) begin
      step((i < tbl.size()) ? tbl[i].mask : 16'h0);
      check_frame("tbl", i - 1, tbl[i-1].v, tbl[i-1].h, tbl[i-1].code, tbl[i-1].m);
    end

    // Random frames continuing from the table's final idle state.
    m_st = S_IDLE; m_cnt = 0; m_held = 0; m_multi = 0; m_cand = 4'd15; m_code = 4'd15;
    model_frame(16'h0, pv);
    fav = $urandom_range(0, 15);
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) mk = 16'h0;
      else if (r < 8) mk = km(fav);
      else if (r == 8) mk = km($urandom_range(0, 15));
      else begin
        s0 = $urandom_range(0, 15);
        mk = km(s0) | km((s0 + 1 + $urandom_range(0, 14)) % 16);
      end
      if ($urandom_range(0, 14) == 0) fav = $urandom_range(0, 15);
      step(mk);
      check_frame("rnd", i, pv, m_held, int'(m_code), m_multi);
      model_frame(mk, pv);
    end
    step(16'h0);
    check_frame("rnd", 120, pv, m_held, int'(m_code), m_multi);

    // Reset in the middle of a held key 9.
    pressed = 16'h0;
    pulse_reset();
    repeat ($urandom_range(0, 15)) @(negedge clk);
    pressed = km(9);
    wait_valid(70, cyc);
    check("press9.found_within_70", (cyc > 0) ? 1 : 0, 1);
    check("press9.key_code", int'(key_code), 9);
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst.key_held", int'(key_held), 0);
    check("midrst.key_code", int'(key_code), 0);
    check("midrst.col", int'(col), 4'b1110);
    check("midrst.key_valid", int'(key_valid), 0);
    check("midrst.multi_key", int'(multi_key), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    s0 = valid_cnt;
    wait_valid(70, cyc);
    check("repress9.found_within_70", (cyc > 0) ? 1 : 0, 1);
    check("repress9.key_code", int'(key_code), 9);
    check("repress9.key_held", int'(key_held), 1);
    repeat (60) @(negedge clk);
    #1;
    check("repress9.valid_pulses", valid_cnt - s0, 1);
    pressed = 16'h0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
